// File: rtl/fsm_butterfly_pkg.sv
// Shared definitions for the fsm_butterfly block.
// Contents:
//   state_t         - FSM state encoding (IDLE, MR0, MR1, MI0, MI1, ADD, DONE)
//   DEF_DATA_W      - default data width (Q2.5 at defaults)
//   DEF_FRAC_W      - default fractional bit count
//   DEF_ROUND_BIAS  - half-LSB bias for the default fraction width
//   round_bias()    - half-LSB bias for an arbitrary fraction width
package fsm_butterfly_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MR0  = 3'd1,
    MR1  = 3'd2,
    MI0  = 3'd3,
    MI1  = 3'd4,
    ADD  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FRAC_W     = 5;
  localparam int DEF_ROUND_BIAS = 1 << (DEF_FRAC_W - 1);

  function automatic int round_bias(input int frac_w);
    return 1 << (frac_w - 1);
  endfunction

endpackage

// File: rtl/fsm_butterfly_if.sv
// Handshake and data bundle of the fsm_butterfly block.
// Signals:
//   enable        - start request (master -> slave)
//   end_f         - result-consumed acknowledge (master -> slave)
//   in1_*, in2_*  - operands a and b, signed DATA_W (master -> slave)
//   out1_*        - a + b*W, signed DATA_W (slave -> master)
//   out2_*        - a - b*W, signed DATA_W (slave -> master)
//   right_data_f  - outputs valid (slave -> master)
// Modports: master (requester side), slave (the butterfly).
interface fsm_butterfly_if
  import fsm_butterfly_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic                     enable;
  logic                     end_f;
  logic signed [DATA_W-1:0] in1_real;
  logic signed [DATA_W-1:0] in1_imag;
  logic signed [DATA_W-1:0] in2_real;
  logic signed [DATA_W-1:0] in2_imag;
  logic signed [DATA_W-1:0] out1_real;
  logic signed [DATA_W-1:0] out1_imag;
  logic signed [DATA_W-1:0] out2_real;
  logic signed [DATA_W-1:0] out2_imag;
  logic                     right_data_f;

  modport master (
    output enable, end_f, in1_real, in1_imag, in2_real, in2_imag,
    input  out1_real, out1_imag, out2_real, out2_imag, right_data_f
  );

  modport slave (
    input  enable, end_f, in1_real, in1_imag, in2_real, in2_imag,
    output out1_real, out1_imag, out2_real, out2_imag, right_data_f
  );
endinterface

// File: rtl/fsm_butterfly_datapath.sv
// butterfly_datapath: shared multiply-accumulate, rounding, add/sub and
// narrowing for the radix-2 butterfly. Sequenced by the FSM state.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   state                - current FSM state (selects MAC operands)
//   a_re, a_im           - captured operand a
//   b_re, b_im           - captured operand b
//   sum_re, sum_im       - narrowed a + t (t = b*W)
//   dif_re, dif_im       - narrowed a - t
// Configuration macro: FSM_BUTTERFLY_SAT_EN selects saturation on the
// final narrowing; without it results wrap to the low DATA_W bits.
module butterfly_datapath
  import fsm_butterfly_pkg::*;
#(
  parameter int                       DATA_W = DEF_DATA_W,
  parameter int                       FRAC_W = DEF_FRAC_W,
  parameter logic signed [DATA_W-1:0] W_RE   = 8'sb001_00000,
  parameter logic signed [DATA_W-1:0] W_IM   = 8'sb000_10000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  state_t                   state,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic signed [DATA_W-1:0] sum_re,
  output logic signed [DATA_W-1:0] sum_im,
  output logic signed [DATA_W-1:0] dif_re,
  output logic signed [DATA_W-1:0] dif_im
);
  localparam int ACC_W = 2 * DATA_W + 1;
  localparam int BIA_W = ACC_W + 1;
  localparam int T_W   = DATA_W + 2;
  localparam int S_W   = DATA_W + 3;

  logic signed [DATA_W-1:0] mul_x;
  logic signed [DATA_W-1:0] mul_c;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [T_W-1:0]    tr;
  logic signed [T_W-1:0]    ti;

  // Round half up: add half an LSB, then arithmetic shift out the fraction.
  function automatic logic signed [T_W-1:0] round_t(input logic signed [ACC_W-1:0] v);
    logic signed [BIA_W-1:0] biased;
    logic signed [BIA_W-1:0] shifted;
    biased  = BIA_W'(v) + BIA_W'(round_bias(FRAC_W));
    shifted = biased >>> FRAC_W;
    return T_W'(shifted);
  endfunction

  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [S_W-1:0] v);
`ifdef FSM_BUTTERFLY_SAT_EN
    // In range when every bit above the target sign bit copies the sign.
    if (v[S_W-1:DATA_W-1] == {(S_W-DATA_W+1){v[S_W-1]}})
      return v[DATA_W-1:0];
    else if (v[S_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Operand steering for the single shared multiplier:
  // MR0 br*W_RE, MR1 bi*W_IM, MI0 br*W_IM, MI1 bi*W_RE.
  always_comb begin
    mul_x = b_im;
    mul_c = W_IM;
    case (state)
      MR0: begin mul_x = b_re; mul_c = W_RE; end
      MR1: begin mul_x = b_im; mul_c = W_IM; end
      MI0: begin mul_x = b_re; mul_c = W_IM; end
      MI1: begin mul_x = b_im; mul_c = W_RE; end
      default: ;
    endcase
  end

  assign prod = ACC_W'(mul_x) * ACC_W'(mul_c);

  // ---- MAC stage: products accumulate, twiddled terms registered ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      tr  <= '0;
      ti  <= '0;
    end else begin
      case (state)
        MR0, MI0: acc <= prod;
        MR1:      tr  <= round_t(acc - prod);
        MI1:      ti  <= round_t(acc + prod);
        default:  ;
      endcase
    end
  end

  // ---- Add/sub stage: combinational, registered by the top in ADD ----
  assign sum_re = narrow(S_W'(a_re) + S_W'(tr));
  assign sum_im = narrow(S_W'(a_im) + S_W'(ti));
  assign dif_re = narrow(S_W'(a_re) - S_W'(tr));
  assign dif_im = narrow(S_W'(a_im) - S_W'(ti));

endmodule

// File: rtl/fsm_butterfly.sv
// fsm_butterfly: multi-cycle radix-2 butterfly, out1 = a + b*W and
// out2 = a - b*W, sequenced by a seven-state FSM around one shared MAC.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fsm_butterfly_if.slave (enable/end_f handshake, operands,
//          registered results and right_data_f)
// Configuration macro: FSM_BUTTERFLY_SAT_EN (saturating narrowing,
// handled inside butterfly_datapath); default build wraps.
module fsm_butterfly
  import fsm_butterfly_pkg::*;
#(
  parameter int                       DATA_W = DEF_DATA_W,
  parameter int                       FRAC_W = DEF_FRAC_W,
  parameter logic signed [DATA_W-1:0] W_RE   = 8'sb001_00000,
  parameter logic signed [DATA_W-1:0] W_IM   = 8'sb000_10000
) (
  input logic             clk,
  input logic             rst,
  fsm_butterfly_if.slave  bus
);
  state_t state, state_nxt;

  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [DATA_W-1:0] sum_re, sum_im, dif_re, dif_im;
  logic signed [DATA_W-1:0] out1_re_q, out1_im_q, out2_re_q, out2_im_q;
  logic                     rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.enable) state_nxt = MR0;
      MR0:     state_nxt = MR1;
      MR1:     state_nxt = MI0;
      MI0:     state_nxt = MI1;
      MI1:     state_nxt = ADD;
      ADD:     state_nxt = DONE;
      DONE:    if (bus.end_f) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- Capture stage: operands frozen on the start edge ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_re <= '0;
      a_im <= '0;
      b_re <= '0;
      b_im <= '0;
    end else if (state == IDLE && bus.enable) begin
      a_re <= bus.in1_real;
      a_im <= bus.in1_imag;
      b_re <= bus.in2_real;
      b_im <= bus.in2_imag;
    end
  end

  butterfly_datapath #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .W_RE   (W_RE),
    .W_IM   (W_IM)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .state  (state),
    .a_re   (a_re),
    .a_im   (a_im),
    .b_re   (b_re),
    .b_im   (b_im),
    .sum_re (sum_re),
    .sum_im (sum_im),
    .dif_re (dif_re),
    .dif_im (dif_im)
  );

  // ---- Output stage: results latched leaving ADD, held until next ADD ----
  // The valid flag tracks "next state is DONE", so it rises with the data
  // and drops on the edge that leaves DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_re_q <= '0;
      out1_im_q <= '0;
      out2_re_q <= '0;
      out2_im_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      if (state == ADD) begin
        out1_re_q <= sum_re;
        out1_im_q <= sum_im;
        out2_re_q <= dif_re;
        out2_im_q <= dif_im;
      end
      rdy_q <= (state_nxt == DONE);
    end
  end

  assign bus.out1_real    = out1_re_q;
  assign bus.out1_imag    = out1_im_q;
  assign bus.out2_real    = out2_re_q;
  assign bus.out2_imag    = out2_im_q;
  assign bus.right_data_f = rdy_q;

endmodule

// File: tb/tb_fsm_butterfly.sv
// Directed, table-driven bench for fsm_butterfly at default parameters
// (Q2.5, W = 1.0 + j0.5). Expected values are hand-computed; the saturating
// build is selected with FSM_BUTTERFLY_SAT_EN, as for the RTL.
module tb_fsm_butterfly;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fsm_butterfly_if #(.DATA_W(8)) bus ();

  fsm_butterfly dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string name;
    int i1r, i1i, i2r, i2i;
    int o1r, o1i, o2r, o2i;
  } vec_t;

  vec_t vecs[8];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int a, input int b, input int c, input int d);
    bus.in1_real = 8'(a);
    bus.in1_imag = 8'(b);
    bus.in2_real = 8'(c);
    bus.in2_imag = 8'(d);
  endtask

  // Presents operands with enable for one sampling edge, then scrambles the
  // inputs so that any late re-capture shows up in the result.
  task automatic start_op(input vec_t v);
    set_in(v.i1r, v.i1i, v.i2r, v.i2i);
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    set_in(99, -99, 77, -77);
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!bus.right_data_f && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".out1_real"}, int'(bus.out1_real), v.o1r);
    check({tag, ".out1_imag"}, int'(bus.out1_imag), v.o1i);
    check({tag, ".out2_real"}, int'(bus.out2_real), v.o2r);
    check({tag, ".out2_imag"}, int'(bus.out2_imag), v.o2i);
    check({tag, ".right_data_f"}, int'(bus.right_data_f), 1);
  endtask

  task automatic release_result(input string tag);
    bus.end_f = 1'b1;
    tick();
    bus.end_f = 1'b0;
    check({tag, ".rdf_clear"}, int'(bus.right_data_f), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out1_real"}, int'(bus.out1_real), 0);
    check({tag, ".out1_imag"}, int'(bus.out1_imag), 0);
    check({tag, ".out2_real"}, int'(bus.out2_real), 0);
    check({tag, ".out2_imag"}, int'(bus.out2_imag), 0);
    check({tag, ".right_data_f"}, int'(bus.right_data_f), 0);
  endtask

  initial begin
    int e;

    vecs[0] = '{"nominal", 51, -45, 37, -56, 116, -82, -14, -8};
`ifdef FSM_BUTTERFLY_SAT_EN
    vecs[1] = '{"sat_pos", 113, 85, 22, -22, 127, 74, 80, 96};
    vecs[6] = '{"sat_neg", -128, -100, 64, 64, -96, -4, -128, -128};
    vecs[7] = '{"extreme", 127, 127, -128, -128, 63, -65, 127, 127};
`else
    vecs[1] = '{"sat_pos", 113, 85, 22, -22, -110, 74, 80, 96};
    vecs[6] = '{"sat_neg", -128, -100, 64, 64, -96, -4, 96, 60};
    vecs[7] = '{"extreme", 127, 127, -128, -128, 63, -65, -65, 63};
`endif
    vecs[2] = '{"b_zero", 10, -20, 0, 0, 10, -20, 10, -20};
    vecs[3] = '{"b_one", 0, 0, 32, 0, 32, 16, -32, -16};
    vecs[4] = '{"half_up", 5, 5, 1, 1, 6, 7, 4, 3};
    vecs[5] = '{"neg_half", 0, 0, -1, -1, 0, -1, 0, 1};

    // Reset held with enable high: nothing starts, everything stays zero.
    bus.enable = 1'b1;
    bus.end_f  = 1'b0;
    set_in(51, -45, 37, -56);
    repeat (3) tick();
    check_zero("reset");
    bus.enable = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    check("reset.no_start", int'(bus.right_data_f), 0);

    // Table of operand sets: latency, results, release.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i]);
      wait_done(e);
      check({vecs[i].name, ".latency"}, e, 5);
      check_outs(vecs[i].name, vecs[i]);
      release_result(vecs[i].name);
    end

    // end_f while busy is ignored; result held while end_f stays low.
    start_op(vecs[0]);
    bus.end_f = 1'b1;
    tick();
    bus.end_f = 1'b0;
    wait_done(e);
    check("hold.latency", e, 4);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("hold.rdf[%0d]", k), int'(bus.right_data_f), 1);
      check($sformatf("hold.out1_real[%0d]", k), int'(bus.out1_real), 116);
      check($sformatf("hold.out2_imag[%0d]", k), int'(bus.out2_imag), -8);
    end
    release_result("hold");

    // enable re-pulsed in MR1 with new inputs must not disturb the result.
    start_op(vecs[1]);
    set_in(1, 2, 3, 4);
    bus.enable = 1'b1;
    tick();
    tick();
    bus.enable = 1'b0;
    wait_done(e);
    check("busy.latency", e, 3);
    check_outs("busy", vecs[1]);
    release_result("busy");

    // Reset in MI0 aborts: outputs clear at once, FSM parks in IDLE.
    start_op(vecs[0]);
    tick();
    tick();
    rst = 1'b1;
    #2;
    check_zero("abort");
    rst = 1'b0;
    repeat (8) tick();
    check("abort.idle", int'(bus.right_data_f), 0);
    start_op(vecs[2]);
    wait_done(e);
    check("abort.restart_latency", e, 5);
    check_outs("abort.restart", vecs[2]);
    release_result("abort");

    // enable and end_f together in DONE: back to IDLE, then a fresh start.
    start_op(vecs[3]);
    wait_done(e);
    check_outs("b2b.first", vecs[3]);
    set_in(vecs[4].i1r, vecs[4].i1i, vecs[4].i2r, vecs[4].i2i);
    bus.enable = 1'b1;
    bus.end_f  = 1'b1;
    tick();
    bus.end_f = 1'b0;
    check("b2b.rdf_clear", int'(bus.right_data_f), 0);
    check("b2b.out1_held", int'(bus.out1_real), vecs[3].o1r);
    tick();
    bus.enable = 1'b0;
    set_in(99, -99, 77, -77);
    wait_done(e);
    check("b2b.latency", e, 5);
    check_outs("b2b.second", vecs[4]);
    release_result("b2b");

    // enable held high: a new operation begins on each return to IDLE.
    set_in(vecs[5].i1r, vecs[5].i1i, vecs[5].i2r, vecs[5].i2i);
    bus.enable = 1'b1;
    tick();
    wait_done(e);
    check("held.latency", e, 5);
    check_outs("held.first", vecs[5]);
    bus.end_f = 1'b1;
    tick();
    bus.end_f = 1'b0;
    check("held.rdf_clear", int'(bus.right_data_f), 0);
    wait_done(e);
    check("held.relatency", e, 6);
    bus.enable = 1'b0;
    check_outs("held.second", vecs[5]);
    release_result("held");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
